// File: rtl/dpram_be_sc.sv
// Single-clock true dual-port RAM with byte lanes, selectable read-during-write,
// optional output register and a post-reset clear sweep.
module dpram_be_sc #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    localparam int NBYTES = DATA_W / 8,
    parameter int RDW_NEW = 1,
    parameter int OUT_REG = 0,
    parameter int CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              init_busy,
    output logic              collision,

    input  logic              wren_a,
    input  logic [NBYTES-1:0] byteena_a,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] q_a,

    input  logic              wren_b,
    input  logic [NBYTES-1:0] byteena_b,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] q_b
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic              clear_we;
    logic              run;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [NBYTES-1:0] wmask_a, wmask_b;
    logic              col_now;

    logic [DATA_W-1:0] raw_a_reg, raw_b_reg;
    logic              rd_valid_reg;
    logic [NBYTES-1:0] rmask_a_reg, rmask_b_reg;
    logic [NBYTES-1:0] wmask_a_reg, wmask_b_reg;
    logic [DATA_W-1:0] wdata_a_reg, wdata_b_reg;
    logic              col1_reg;

    logic [DATA_W-1:0] rd_a, rd_b;
    logic [DATA_W-1:0] q1_a, q1_b;

    // ---------------- clear sequencer ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= RESET_STATE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        clear_we   = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                clear_we = 1'b1;
                cnt_next = cnt_reg + 1'b1;
                if (&cnt_reg) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
            end
        endcase
    end

    assign init_busy = (state_reg == ST_CLEAR);
    assign run       = (state_reg == ST_RUN);

    // ---------------- write qualification ----------------
    assign wmask_a = (run && wren_a) ? byteena_a : '0;
    assign wmask_b = (run && wren_b) ? byteena_b : '0;
    assign col_now = (address_a == address_b) && (|(wmask_a & wmask_b));

    // ---------------- storage ----------------
    // B lanes are written first so that A's assignments win on shared lanes.
    always_ff @(posedge clock) begin
        if (clear_we) begin
            mem[cnt_reg] <= CLEAR_VALUE;
        end
        for (int i = 0; i < NBYTES; i++) begin
            if (wmask_b[i]) begin
                mem[address_b][8*i +: 8] <= data_b[8*i +: 8];
            end
        end
        for (int i = 0; i < NBYTES; i++) begin
            if (wmask_a[i]) begin
                mem[address_a][8*i +: 8] <= data_a[8*i +: 8];
            end
        end
        raw_a_reg <= mem[address_a];
        raw_b_reg <= mem[address_b];
    end

    // ---------------- read-side bookkeeping ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_reg <= 1'b0;
            rmask_a_reg  <= '0;
            rmask_b_reg  <= '0;
            wmask_a_reg  <= '0;
            wmask_b_reg  <= '0;
            wdata_a_reg  <= '0;
            wdata_b_reg  <= '0;
            col1_reg     <= 1'b0;
        end else begin
            rd_valid_reg <= run;
            rmask_a_reg  <= byteena_a;
            rmask_b_reg  <= byteena_b;
            wmask_a_reg  <= wmask_a;
            wmask_b_reg  <= wmask_b;
            wdata_a_reg  <= data_a;
            wdata_b_reg  <= data_b;
            col1_reg     <= col_now;
        end
    end

    // Disabled lanes read as 0xFF; a port's own write overrides the raw
    // word only in new-data mode.
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
        assign rd_a[8*gi +: 8] = !rmask_a_reg[gi] ? 8'hFF :
                                 ((RDW_NEW != 0) && wmask_a_reg[gi]) ? wdata_a_reg[8*gi +: 8] :
                                 raw_a_reg[8*gi +: 8];
        assign rd_b[8*gi +: 8] = !rmask_b_reg[gi] ? 8'hFF :
                                 ((RDW_NEW != 0) && wmask_b_reg[gi]) ? wdata_b_reg[8*gi +: 8] :
                                 raw_b_reg[8*gi +: 8];
    end

    assign q1_a = rd_valid_reg ? rd_a : '0;
    assign q1_b = rd_valid_reg ? rd_b : '0;

    // ---------------- optional output stage ----------------
    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_W-1:0] q_a_reg, q_b_reg;
        logic              col2_reg;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                q_a_reg  <= '0;
                q_b_reg  <= '0;
                col2_reg <= 1'b0;
            end else begin
                q_a_reg  <= q1_a;
                q_b_reg  <= q1_b;
                col2_reg <= col1_reg;
            end
        end

        assign q_a       = q_a_reg;
        assign q_b       = q_b_reg;
        assign collision = col2_reg;
    end else begin : g_direct
        assign q_a       = q1_a;
        assign q_b       = q1_b;
        assign collision = col1_reg;
    end

endmodule
